multi_tone_divider: RTL and testbench
=====================================

// Module: multi_tone_divider
// PURPOSE
//  - NUM_CH independent programmable square-wave dividers off one system clock (50 MHz on DE1-SoC).
//  - Each channel's divisor is written at runtime over a simple write port, not fixed switch-selected constants.
//  - Drives audio tones (several notes at once) and slow LED/state-machine strobes.
//  - Sits between the switch/key decode logic and the audio or LED outputs.
// PARAMETERS
//  - NUM_CH       4      number of divider channels (1..16)
//  - DIV_W        16     divisor width in bits; max half-period = 2**DIV_W-1 cycles
//  - DEFAULT_DIV  47801  divisor loaded into every channel at reset (~523 Hz at 50 MHz)
// PORTS
//  - CLK_in    in   1                   system clock; all logic on posedge
//  - reset     in   1                   synchronous, active-high reset
//  - wr_en     in   1                   divisor write strobe, one cycle per write
//  - wr_ch     in   max(1,$clog2(NUM_CH)) target channel of write
//  - wr_div    in   DIV_W               new divisor value (half-period in CLK_in cycles)
//  - ch_en     in   NUM_CH              per-channel run enable
//  - CLK_out   out  NUM_CH              divided square-wave outputs, registered
//  - tick      out  NUM_CH              one-cycle pulse in the cycle CLK_out[i] toggles
// BEHAVIOUR
//  - Per channel i: pending divisor pend[i], active divisor act[i], counter cnt[i] (DIV_W bits), output CLK_out[i].
//  - Reset (sync, reset=1 at posedge):
//    - pend = act = DEFAULT_DIV
//    - cnt = 0, CLK_out = 0, tick = 0
//    - Reset overrides any same-cycle write.
//  - Write:
//    - wr_en=1 with wr_ch<NUM_CH sets pend[wr_ch]<=wr_div at that edge.
//    - wr_ch>=NUM_CH is ignored.
//    - Back-to-back writes: last write wins.
//  - Counting (ch_en[i]=1, act[i]!=0):
//    - Each cycle, if cnt==act-1: cnt<=0, CLK_out<=~CLK_out, tick<=1, act<=pend.
//    - Otherwise: cnt<=cnt+1, tick<=0.
//    - Output period = 2*act cycles; f_out = f_clk/(2*act).
//  - act=1: output toggles every cycle (f_clk/2), tick held high.
//  - Glitch-free retune: a new divisor takes effect only at a toggle, so no runt half-period occurs.
//  - A write landing in the same cycle as a toggle is not captured by that toggle; it applies at the following toggle.
//  - Divisor 0 = channel off:
//    - Loaded at a toggle, act=0 forces CLK_out<=0, cnt<=0, tick=0 from the next cycle.
//    - While act=0, act<=pend every cycle. A nonzero write restarts the channel with cnt=0 two cycles after wr_en (write edge, then load edge).
//  - ch_en[i]=0:
//    - cnt, CLK_out and act hold; tick=0; writes to pend still accepted.
//    - On re-enable, counting resumes from the held cnt.
//  - Counter never wraps: cnt<act<=2**DIV_W-1 always.
//  - Channels are fully independent; simultaneous toggles on several channels are all honoured.
// CONFIGURATION
//  - Macro PHASE_SYNC_EN.
//  - Defined:
//    - Adds input port `sync` (1 bit).
//    - sync=1 at an edge sets every channel to cnt<=0, CLK_out<=0, act<=pend, tick<=0, regardless of ch_en, so all channels restart phase-aligned.
//    - reset has priority over sync; a same-cycle write is captured into pend but not into act.
//  - Undefined: no sync port; channels align only via reset.
// TESTING
//  1. Reset: after reset, NUM_CH=4, ch_en=4'hF -> first toggle on all CLK_out after 47801 cycles; period 95602 cycles.
//  2. Retune: write ch1 div=3 mid-half-period -> old half-period completes unshortened, then ch1 period=6 cycles, tick every 3 cycles.
//  3. Edge divisors: div=1 -> CLK_out toggles every cycle, tick stuck high; div=0 -> output low within one toggle and stays low.
//  4. Enable and bad channel: ch_en[2]=0 for 100 cycles -> CLK_out[2] and cnt frozen, total period stretched by 100; write wr_ch=5 -> no channel changes.
//  5. Same-cycle write: write coincident with a toggle -> old divisor used for one more half-period.
//  6. PHASE_SYNC_EN: channels at divisors 5 and 7, pulse sync -> both outputs low and cnt=0 next cycle, first toggles at +5 and +7 cycles.

Source files
------------

// File: rtl/multi_tone_divider.sv
// multi_tone_divider: NUM_CH runtime-programmable square-wave dividers with glitch-free retune.
// Optional macro PHASE_SYNC_EN adds a sync input that restarts every channel phase-aligned.
module multi_tone_divider #(
    parameter int NUM_CH      = 4,
    parameter int DIV_W       = 16,
    parameter int DEFAULT_DIV = 47801,
    localparam int CH_W       = NUM_CH > 1 ? $clog2(NUM_CH) : 1
) (
    input  logic              CLK_in,
    input  logic              reset,
`ifdef PHASE_SYNC_EN
    input  logic              sync,
`endif
    input  logic              wr_en,
    input  logic [CH_W-1:0]   wr_ch,
    input  logic [DIV_W-1:0]  wr_div,
    input  logic [NUM_CH-1:0] ch_en,
    output logic [NUM_CH-1:0] CLK_out,
    output logic [NUM_CH-1:0] tick
);

    logic sync_i;
`ifdef PHASE_SYNC_EN
    assign sync_i = sync;
`else
    assign sync_i = 1'b0;
`endif

    genvar c;
    generate
        for (c = 0; c < NUM_CH; c++) begin : g_ch
            logic [DIV_W-1:0] pend, act, cnt;
            logic             out_q, tick_q, hit, off, wrap;
            // Out-of-range channel numbers never match any c, so they are dropped here.
            assign hit  = wr_en && wr_ch == CH_W'(c);
            assign off  = act == '0;
            assign wrap = cnt == act - DIV_W'(1);
            assign CLK_out[c] = out_q;
            assign tick[c]    = tick_q;
            // act only reloads at a toggle (or while off), so a retune never shortens a half-period.
            always_ff @(posedge CLK_in) begin
                if (reset) begin
                    pend   <= DIV_W'(DEFAULT_DIV);
                    act    <= DIV_W'(DEFAULT_DIV);
                    cnt    <= '0;
                    out_q  <= 1'b0;
                    tick_q <= 1'b0;
                end else begin
                    if (hit)
                        pend <= wr_div;
                    if (sync_i) begin
                        cnt    <= '0;
                        out_q  <= 1'b0;
                        act    <= pend;
                        tick_q <= 1'b0;
                    end else if (!ch_en[c]) begin
                        tick_q <= 1'b0;
                    end else if (off) begin
                        cnt    <= '0;
                        out_q  <= 1'b0;
                        act    <= pend;
                        tick_q <= 1'b0;
                    end else if (wrap) begin
                        cnt    <= '0;
                        out_q  <= ~out_q;
                        act    <= pend;
                        tick_q <= 1'b1;
                    end else begin
                        cnt    <= cnt + DIV_W'(1);
                        tick_q <= 1'b0;
                    end
                end
            end
        end
    endgenerate

endmodule

// File: tb/tb_multi_tone_divider.sv
// tb_multi_tone_divider: directed checks of reset timing, retune, edge divisors, enable and write decode.
module tb_multi_tone_divider;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        wr_en = 1'b0;
    logic [1:0]  wr_ch = '0;
    logic [15:0] wr_div = '0;
    logic [3:0]  ch_en = 4'hF;
    logic [3:0]  clk_out, tick;
    logic        b_wr_en = 1'b0;
    logic [2:0]  b_wr_ch = '0;
    logic [7:0]  b_wr_div = '0;
    logic [4:0]  b_ch_en = 5'h1F;
    logic [4:0]  b_out, b_tick;
`ifdef PHASE_SYNC_EN
    logic        sync = 1'b0;
`endif
    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    multi_tone_divider dut (
        .CLK_in(clk), .reset(reset),
`ifdef PHASE_SYNC_EN
        .sync(sync),
`endif
        .wr_en(wr_en), .wr_ch(wr_ch), .wr_div(wr_div), .ch_en(ch_en),
        .CLK_out(clk_out), .tick(tick)
    );

    // Small second instance: 3-bit channel select makes out-of-range writes expressible.
    multi_tone_divider #(.NUM_CH(5), .DIV_W(8), .DEFAULT_DIV(3)) u_b (
        .CLK_in(clk), .reset(reset),
`ifdef PHASE_SYNC_EN
        .sync(sync),
`endif
        .wr_en(b_wr_en), .wr_ch(b_wr_ch), .wr_div(b_wr_div), .ch_en(b_ch_en),
        .CLK_out(b_out), .tick(b_tick)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_toggle(input int ch, input int limit, output int n);
        logic s;
        s = clk_out[ch];
        n = -1;
        for (int i = 1; i <= limit; i++) begin
            step();
            if (clk_out[ch] !== s) begin
                n = i;
                break;
            end
        end
    endtask

    task automatic test_reset();
        logic [29:0] b_hist;
        logic low;
        reset = 1'b1; b_wr_en = 1'b1; b_wr_ch = 3'd0; b_wr_div = 8'd1;
        step();
        n_cmp++;
        if ({clk_out, tick} !== 8'h00) begin
            n_bad++; $display("FAIL reset_main: out/tick=%h expected 00", {clk_out, tick});
        end
        n_cmp++;
        if ({b_out, b_tick} !== 10'h000) begin
            n_bad++; $display("FAIL reset_b: out/tick=%h expected 000", {b_out, b_tick});
        end
        reset = 1'b0; b_wr_en = 1'b0;
        low = 1'b1; b_hist = '0;
        for (int i = 1; i <= 47800; i++) begin
            wr_en  = i <= 4;
            wr_ch  = 2'(i - 1);
            wr_div = i == 1 ? 16'd3 : i == 2 ? 16'd5 : i == 3 ? 16'd6 : 16'd1;
            step();
            if (clk_out !== 4'h0 || tick !== 4'h0) low = 1'b0;
            if (i <= 6) b_hist = {b_hist[24:0], b_out};
        end
        wr_en = 1'b0;
        n_cmp++;
        if (b_hist !== {5'h00, 5'h00, 5'h1F, 5'h1F, 5'h1F, 5'h00}) begin
            n_bad++; $display("FAIL reset_write_override: hist=%h expected %h", b_hist, {5'h00, 5'h00, 5'h1F, 5'h1F, 5'h1F, 5'h00});
        end
        n_cmp++;
        if (low !== 1'b1) begin
            n_bad++; $display("FAIL first_half_period: early activity=%b expected none", ~low);
        end
        step();
        n_cmp++;
        if (clk_out !== 4'hF) begin
            n_bad++; $display("FAIL first_toggle_out: got %h expected F", clk_out);
        end
        n_cmp++;
        if (tick !== 4'hF) begin
            n_bad++; $display("FAIL first_toggle_tick: got %h expected F", tick);
        end
    endtask

    task automatic test_retune();
        int n;
        logic [5:0] th, oh;
        step();
        wr_en = 1'b1; wr_ch = 2'd1; wr_div = 16'd3;
        step();
        wr_en = 1'b0;
        wait_toggle(1, 20, n);
        n_cmp++;
        if (n !== 3) begin
            n_bad++; $display("FAIL retune_old_half: got %0d expected 3", n);
        end
        n_cmp++;
        if (tick[1] !== 1'b1) begin
            n_bad++; $display("FAIL retune_tick: got %b expected 1", tick[1]);
        end
        th = '0; oh = '0;
        for (int i = 0; i < 6; i++) begin
            step();
            th = {th[4:0], tick[1]};
            oh = {oh[4:0], clk_out[1]};
        end
        n_cmp++;
        if (th !== 6'b001001) begin
            n_bad++; $display("FAIL retune_tick_pattern: got %b expected 001001", th);
        end
        n_cmp++;
        if (oh !== 6'b001110) begin
            n_bad++; $display("FAIL retune_out_pattern: got %b expected 001110", oh);
        end
    endtask

    task automatic test_edge_div();
        int n;
        logic s;
        logic [3:0] oh, th;
        logic [11:0] zh;
        s = clk_out[3]; oh = '0; th = '0;
        for (int i = 0; i < 4; i++) begin
            step();
            oh = {oh[2:0], clk_out[3]};
            th = {th[2:0], tick[3]};
        end
        n_cmp++;
        if (oh !== (s ? 4'b0101 : 4'b1010)) begin
            n_bad++; $display("FAIL div1_out: got %b expected %b", oh, s ? 4'b0101 : 4'b1010);
        end
        n_cmp++;
        if (th !== 4'hF) begin
            n_bad++; $display("FAIL div1_tick: got %b expected 1111", th);
        end
        wr_en = 1'b1; wr_ch = 2'd3; wr_div = 16'd0;
        step();
        wr_en = 1'b0;
        step();
        step();
        zh = '0;
        for (int i = 0; i < 6; i++) begin
            zh = {zh[9:0], clk_out[3], tick[3]};
            step();
        end
        n_cmp++;
        if (zh !== 12'h000) begin
            n_bad++; $display("FAIL div0_off: out/tick history=%h expected 000", zh);
        end
        wr_en = 1'b1; wr_ch = 2'd3; wr_div = 16'd2;
        step();
        wr_en = 1'b0;
        wait_toggle(3, 10, n);
        n_cmp++;
        if (n !== 3) begin
            n_bad++; $display("FAIL div0_restart: got %0d expected 3", n);
        end
        n_cmp++;
        if ({clk_out[3], tick[3]} !== 2'b11) begin
            n_bad++; $display("FAIL div0_restart_edge: got %b expected 11", {clk_out[3], tick[3]});
        end
    endtask

    task automatic test_enable();
        int n;
        logic s, frozen;
        wait_toggle(2, 20, n);
        n_cmp++;
        if (n < 1) begin
            n_bad++; $display("FAIL enable_sync: got %0d expected a toggle", n);
        end
        step();
        step();
        ch_en = 4'b1011;
        s = clk_out[2]; frozen = 1'b1;
        for (int i = 0; i < 100; i++) begin
            step();
            if (clk_out[2] !== s || tick[2] !== 1'b0) frozen = 1'b0;
        end
        ch_en = 4'hF;
        n_cmp++;
        if (frozen !== 1'b1) begin
            n_bad++; $display("FAIL enable_freeze: frozen=%b expected 1", frozen);
        end
        wait_toggle(2, 20, n);
        n_cmp++;
        if (n !== 4) begin
            n_bad++; $display("FAIL enable_resume: got %0d expected 4", n);
        end
    endtask

    task automatic test_same_cycle();
        int n;
        wait_toggle(0, 10, n);
        n_cmp++;
        if (n < 1) begin
            n_bad++; $display("FAIL same_cycle_sync: got %0d expected a toggle", n);
        end
        step();
        step();
        wr_en = 1'b1; wr_ch = 2'd0; wr_div = 16'd2;
        step();
        wr_en = 1'b0;
        n_cmp++;
        if (tick[0] !== 1'b1) begin
            n_bad++; $display("FAIL same_cycle_coincide: tick=%b expected 1", tick[0]);
        end
        wait_toggle(0, 10, n);
        n_cmp++;
        if (n !== 3) begin
            n_bad++; $display("FAIL same_cycle_old_div: got %0d expected 3", n);
        end
        wait_toggle(0, 10, n);
        n_cmp++;
        if (n !== 2) begin
            n_bad++; $display("FAIL same_cycle_new_div: got %0d expected 2", n);
        end
    endtask

    task automatic test_bad_channel();
        logic [4:0] v, v2, expv;
        logic found;
        found = 1'b0;
        v = b_out;
        for (int i = 0; i < 10 && !found; i++) begin
            step();
            found = b_out[0] !== v[0];
        end
        n_cmp++;
        if (found !== 1'b1) begin
            n_bad++; $display("FAIL bad_ch_sync: no toggle on b channel 0 expected one");
        end
        v = b_out;
        b_wr_en = 1'b1; b_wr_ch = 3'd5; b_wr_div = 8'd1;
        step();
        b_wr_ch = 3'd7;
        step();
        b_wr_en = 1'b0;
        for (int i = 0; i < 9; i++) begin
            step();
            expv = (i < 3 || i > 5) ? ~v : v;
            n_cmp++;
            if (b_out !== expv) begin
                n_bad++; $display("FAIL bad_ch_ignored step %0d: got %h expected %h", i, b_out, expv);
            end
        end
        step();
        b_wr_en = 1'b1; b_wr_ch = 3'd4; b_wr_div = 8'd1;
        step();
        b_wr_en = 1'b0;
        step();
        step();
        v2 = b_out;
        step();
        n_cmp++;
        if (b_out !== (v2 ^ 5'h10)) begin
            n_bad++; $display("FAIL ch4_fast_out: got %h expected %h", b_out, v2 ^ 5'h10);
        end
        n_cmp++;
        if (b_tick !== 5'h10) begin
            n_bad++; $display("FAIL ch4_fast_tick: got %h expected 10", b_tick);
        end
        step();
        n_cmp++;
        if (b_out !== v2) begin
            n_bad++; $display("FAIL ch4_fast_back: got %h expected %h", b_out, v2);
        end
    endtask

`ifdef PHASE_SYNC_EN
    task automatic test_phase_sync();
        int t0, t1;
        wr_en = 1'b1; wr_ch = 2'd0; wr_div = 16'd5;
        step();
        wr_ch = 2'd1; wr_div = 16'd7;
        step();
        wr_en = 1'b0;
        sync = 1'b1;
        step();
        sync = 1'b0;
        n_cmp++;
        if ({clk_out[1:0], tick[1:0]} !== 4'h0) begin
            n_bad++; $display("FAIL sync_clear: got %h expected 0", {clk_out[1:0], tick[1:0]});
        end
        t0 = 0; t1 = 0;
        for (int i = 1; i <= 8; i++) begin
            step();
            if (t0 == 0 && clk_out[0]) t0 = i;
            if (t1 == 0 && clk_out[1]) t1 = i;
        end
        n_cmp++;
        if (t0 !== 5) begin
            n_bad++; $display("FAIL sync_ch0_first: got %0d expected 5", t0);
        end
        n_cmp++;
        if (t1 !== 7) begin
            n_bad++; $display("FAIL sync_ch1_first: got %0d expected 7", t1);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_retune();
        test_edge_div();
        test_enable();
        test_same_cycle();
        test_bad_channel();
`ifdef PHASE_SYNC_EN
        test_phase_sync();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
